// File: rtl/ifm_window_buffer.sv
// ifm_window_buffer: KxK line-buffer window over a raster pixel stream; ports clk, reset(async low), clear, ifm_valid_in/ifm_data_in in, window_data/window_valid/ofm_address/frame_done out
module ifm_window_buffer #(
  parameter int DATA_WIDTH = 32,
  parameter int IFM_SIZE = 32,
  parameter int KERNAL_SIZE = 5,
  parameter int IFM_SIZE_NEXT = IFM_SIZE - KERNAL_SIZE + 1,
  parameter int ADDRESS_SIZE_NEXT_IFM = $clog2(IFM_SIZE_NEXT * IFM_SIZE_NEXT),
  parameter int FIFO_SIZE = (KERNAL_SIZE - 1) * IFM_SIZE + KERNAL_SIZE
) (
  input  logic                                        clk,
  input  logic                                        reset,
  input  logic                                        clear,
  input  logic                                        ifm_valid_in,
  input  logic [DATA_WIDTH-1:0]                       ifm_data_in,
  output logic [KERNAL_SIZE*KERNAL_SIZE*DATA_WIDTH-1:0] window_data,
  output logic                                        window_valid,
  output logic [ADDRESS_SIZE_NEXT_IFM-1:0]            ofm_address,
  output logic                                        frame_done
);
  localparam int CW = $clog2(IFM_SIZE + 1);
  localparam int AW = ADDRESS_SIZE_NEXT_IFM;
  localparam logic [CW-1:0] POS_LAST = CW'(IFM_SIZE - 1);
  localparam logic [CW-1:0] POS_WIN = CW'(KERNAL_SIZE - 1);
  localparam logic [AW-1:0] ADDR_LAST = AW'(IFM_SIZE_NEXT * IFM_SIZE_NEXT - 1);
  typedef enum logic [1:0] {FILL, ACTIVE, DONE} state_t;
  state_t state_q, state_d;
  logic [FIFO_SIZE*DATA_WIDTH-1:0] shift_q, shift_d;
  logic [CW-1:0] col_cnt_q, col_cnt_d, row_cnt_q, row_cnt_d;
  logic [AW-1:0] ofm_address_q, ofm_address_d;
  logic window_valid_q, window_valid_d;
  logic accept, col_last, row_last;
  always_comb begin
    accept = ifm_valid_in && !clear;
    col_last = col_cnt_q == POS_LAST;
    row_last = row_cnt_q == POS_LAST;
    shift_d = accept ? {shift_q[(FIFO_SIZE-1)*DATA_WIDTH-1:0], ifm_data_in} : shift_q;
    col_cnt_d = clear ? '0 : accept ? (col_last ? '0 : col_cnt_q + 1'b1) : col_cnt_q;
    row_cnt_d = (clear || (accept && col_last && row_last)) ? '0 : (accept && col_last) ? row_cnt_q + 1'b1 : row_cnt_q;
    window_valid_d = accept && row_cnt_q >= POS_WIN && col_cnt_q >= POS_WIN;
    ofm_address_d = clear ? '0 : window_valid_q ? (ofm_address_q == ADDR_LAST ? '0 : ofm_address_q + 1'b1) : ofm_address_q;
    state_d = clear ? FILL :
              (accept && col_last && row_last) ? DONE :
              (state_q == DONE) ? FILL :
              (state_q == FILL && row_cnt_q >= POS_WIN) ? ACTIVE : state_q;
  end
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= FILL;
      shift_q <= '0;
      col_cnt_q <= '0;
      row_cnt_q <= '0;
      ofm_address_q <= '0;
      window_valid_q <= 1'b0;
    end else begin
      state_q <= state_d;
      shift_q <= shift_d;
      col_cnt_q <= col_cnt_d;
      row_cnt_q <= row_cnt_d;
      ofm_address_q <= ofm_address_d;
      window_valid_q <= window_valid_d;
    end
  end
  for (genvar r = 0; r < KERNAL_SIZE; r++) begin : g_row
    for (genvar c = 0; c < KERNAL_SIZE; c++) begin : g_col
      assign window_data[(r*KERNAL_SIZE+c)*DATA_WIDTH +: DATA_WIDTH] =
        shift_q[((KERNAL_SIZE-1-r)*IFM_SIZE + KERNAL_SIZE-1-c)*DATA_WIDTH +: DATA_WIDTH];
    end
  end
  assign window_valid = window_valid_q;
  assign ofm_address = ofm_address_q;
  assign frame_done = state_q == DONE;
endmodule

// File: tb/tb_ifm_window_buffer.sv
// tb_ifm_window_buffer: directed vectors and frame streams against hand-derived window geometry
module tb_ifm_window_buffer;
  localparam int DW = 32;
  localparam int IFM = 32;
  localparam int K = 5;
  localparam int AW = 10;
  logic clk = 1'b0;
  logic reset = 1'b0;
  logic clear = 1'b0;
  logic ifm_valid_in = 1'b0;
  logic [DW-1:0] ifm_data_in = '0;
  logic [K*K*DW-1:0] window_data;
  logic window_valid;
  logic [AW-1:0] ofm_address;
  logic frame_done;
  int checks = 0;
  int errors = 0;
  int pulses = 0;
  typedef struct {int pix; bit wv; int addr; int l0; int l5; int l24;} probe_t;
  probe_t tbl[8];
  always #5 clk = ~clk;
  ifm_window_buffer dut (
    .clk(clk),
    .reset(reset),
    .clear(clear),
    .ifm_valid_in(ifm_valid_in),
    .ifm_data_in(ifm_data_in),
    .window_data(window_data),
    .window_valid(window_valid),
    .ofm_address(ofm_address),
    .frame_done(frame_done)
  );
  function automatic longint lane(int t);
    return longint'(window_data[t*DW +: DW]);
  endfunction
  task automatic chk(string name, longint act, longint exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s got %0d expected %0d", name, act, exp);
    end
  endtask
  task automatic beat(logic v, logic c, logic [DW-1:0] d);
    @(negedge clk);
    ifm_valid_in = v;
    clear = c;
    ifm_data_in = d;
    @(posedge clk);
    #1;
    ifm_valid_in = 1'b0;
    clear = 1'b0;
  endtask
  task automatic stream(int base, int n, bit gaps);
    int k;
    int row;
    int col;
    bit ev;
    k = 0;
    for (int p = 0; p < n; p++) begin
      row = p / IFM;
      col = p % IFM;
      if (gaps && p > 0)
        for (int g = 0; g < 6 && $urandom_range(1) == 1; g++) begin
          beat(1'b0, 1'b0, '0);
          chk("idle_window_valid", window_valid, 0);
          chk("idle_frame_done", frame_done, 0);
        end
      beat(1'b1, 1'b0, DW'(base + p));
      ev = row >= K-1 && col >= K-1;
      chk("window_valid", window_valid, ev);
      chk("frame_done", frame_done, p == IFM*IFM-1);
      if (ev) begin
        pulses++;
        chk("ofm_address", ofm_address, (row-K+1)*(IFM-K+1) + col-K+1);
        chk("lane0", lane(0), base + p - 132);
        chk("lane5", lane(5), base + p - 100);
        chk("lane12", lane(12), base + p - 66);
        chk("lane24", lane(24), base + p);
      end
      if (base == 0 && k < 8 && tbl[k].pix == p) begin
        chk("probe_valid", window_valid, tbl[k].wv);
        chk("probe_addr", ofm_address, tbl[k].addr);
        chk("probe_lane0", lane(0), tbl[k].l0);
        chk("probe_lane5", lane(5), tbl[k].l5);
        chk("probe_lane24", lane(24), tbl[k].l24);
        k++;
      end
    end
  endtask
  initial begin
    tbl[0] = '{131, 1'b0, 0, 0, 31, 131};
    tbl[1] = '{132, 1'b1, 0, 0, 32, 132};
    tbl[2] = '{133, 1'b1, 1, 1, 33, 133};
    tbl[3] = '{159, 1'b1, 27, 27, 59, 159};
    tbl[4] = '{160, 1'b0, 28, 28, 60, 160};
    tbl[5] = '{163, 1'b0, 28, 31, 63, 163};
    tbl[6] = '{164, 1'b1, 28, 32, 64, 164};
    tbl[7] = '{1023, 1'b1, 783, 891, 923, 1023};
    #12;
    chk("reset_window_valid", window_valid, 0);
    chk("reset_ofm_address", ofm_address, 0);
    chk("reset_frame_done", frame_done, 0);
    chk("reset_window_data_zero", window_data == '0, 1);
    @(negedge clk);
    reset = 1'b1;
    stream(0, 1024, 1'b0);
    chk("frame1_pulses", pulses, 784);
    pulses = 0;
    stream(50000, 1024, 1'b1);
    chk("frame2_pulses", pulses, 784);
    beat(1'b0, 1'b0, '0);
    chk("post_frame_done", frame_done, 0);
    chk("post_window_valid", window_valid, 0);
    chk("post_addr_wrap", ofm_address, 0);
    stream(10000, 500, 1'b0);
    beat(1'b1, 1'b1, DW'(99));
    chk("clear_window_valid", window_valid, 0);
    chk("clear_ofm_address", ofm_address, 0);
    chk("clear_frame_done", frame_done, 0);
    chk("clear_keeps_shift", lane(24), 10499);
    stream(20000, 200, 1'b0);
    chk("pre_reset_valid", window_valid, 1);
    #2;
    reset = 1'b0;
    #1;
    chk("async_window_valid", window_valid, 0);
    chk("async_ofm_address", ofm_address, 0);
    chk("async_frame_done", frame_done, 0);
    chk("async_window_data_zero", window_data == '0, 1);
    @(negedge clk);
    @(negedge clk);
    reset = 1'b1;
    stream(30000, 300, 1'b0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
